// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared rename-register-file constants and types for the RRF allocation controller.
package rrf_alloc_ctrl_pkg;

  localparam int unsigned DATA_LEN    = 32;
  localparam int unsigned RRF_NUM     = 64;
  localparam int unsigned RRF_SEL     = 6;
  localparam int unsigned RRF_CNT_LEN = RRF_SEL + 1;

  typedef logic [RRF_SEL-1:0]     rrf_tag_t;
  typedef logic [RRF_CNT_LEN-1:0] rrf_cnt_t;

  // Occupancy implied by a free count; a full buffer (free=0) wraps to 0 like the pointers do.
  function automatic rrf_tag_t used_from_free(input rrf_cnt_t free);
    rrf_cnt_t used;
    used = RRF_CNT_LEN'(RRF_NUM) - free;
    return RRF_SEL'(used);
  endfunction

endpackage

// File: rtl/rrf_alloc_ctrl_if.sv
// Dispatch/commit side bundle between the pipeline and the RRF allocation controller.
interface rrf_alloc_ctrl_if;
  import rrf_alloc_ctrl_pkg::*;

  logic       [1:0] req_num;
  logic             stall_dp;
  logic             allocatable;
  logic             alloc_en1;
  logic             alloc_en2;
  rrf_tag_t         alloc_tag1;
  rrf_tag_t         alloc_tag2;
  logic       [1:0] com_num;
  rrf_tag_t         com_tag1;
  rrf_tag_t         com_tag2;
  logic             prmiss;
  rrf_cnt_t         freenum;
  rrf_tag_t         rrfptr;

  modport master (
    output req_num, stall_dp, com_num, prmiss,
    input  allocatable, alloc_en1, alloc_en2, alloc_tag1, alloc_tag2,
           com_tag1, com_tag2, freenum, rrfptr
  );

  modport slave (
    input  req_num, stall_dp, com_num, prmiss,
    output allocatable, alloc_en1, alloc_en2, alloc_tag1, alloc_tag2,
           com_tag1, com_tag2, freenum, rrfptr
  );

endinterface

// File: rtl/rrf_ptr_adv.sv
// Circular RRF pointer advance by 0..3 with natural tag-width wrap.
module rrf_ptr_adv
  import rrf_alloc_ctrl_pkg::*;
(
  input  rrf_tag_t   ptr,
  input  logic [1:0] num,
  output rrf_tag_t   sum
);

  assign sum = ptr + RRF_SEL'(num);

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// RRF circular-buffer sequencer: allocation/commit pointers, free count and mispredict rollback.
module rrf_alloc_ctrl
  import rrf_alloc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rrf_alloc_ctrl_if.slave   bus
);

  rrf_tag_t   rrfptr;
  rrf_tag_t   comptr;
  rrf_cnt_t   freenum;

  logic       req_ok;
  logic       do_alloc;
  logic [1:0] alloc_num;
  rrf_tag_t   rrfptr_nxt;
  rrf_tag_t   comptr_nxt;
  rrf_tag_t   rrfptr_inc;
  rrf_tag_t   comptr_inc;

  // Request of 3 is never granted; frees from this cycle's commit are not yet visible.
  always_comb begin
    req_ok    = 1'b0;
    do_alloc  = 1'b0;
    alloc_num = 2'd0;
    if (bus.req_num != 2'd3) begin
      req_ok = (RRF_CNT_LEN'(bus.req_num) <= freenum);
    end
    do_alloc = req_ok & ~bus.stall_dp & ~bus.prmiss;
    if (do_alloc) begin
      alloc_num = bus.req_num;
    end
  end

  rrf_ptr_adv u_rrfptr_adv (.ptr(rrfptr), .num(alloc_num),   .sum(rrfptr_nxt));
  rrf_ptr_adv u_comptr_adv (.ptr(comptr), .num(bus.com_num), .sum(comptr_nxt));
  rrf_ptr_adv u_rrfptr_inc (.ptr(rrfptr), .num(2'd1),        .sum(rrfptr_inc));
  rrf_ptr_adv u_comptr_inc (.ptr(comptr), .num(2'd1),        .sum(comptr_inc));

  // Mispredict restores rrfptr to the post-commit comptr, emptying the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrfptr  <= '0;
      comptr  <= '0;
      freenum <= RRF_CNT_LEN'(RRF_NUM);
    end else begin
      comptr <= comptr_nxt;
      if (bus.prmiss) begin
        rrfptr  <= comptr_nxt;
        freenum <= RRF_CNT_LEN'(RRF_NUM);
      end else begin
        rrfptr  <= rrfptr_nxt;
        freenum <= freenum + RRF_CNT_LEN'(bus.com_num) - RRF_CNT_LEN'(alloc_num);
      end
    end
  end

  assign bus.allocatable = req_ok;
  assign bus.alloc_en1   = do_alloc & (bus.req_num != 2'd0);
  assign bus.alloc_en2   = do_alloc & (bus.req_num == 2'd2);
  assign bus.alloc_tag1  = rrfptr;
  assign bus.alloc_tag2  = rrfptr_inc;
  assign bus.com_tag1    = comptr;
  assign bus.com_tag2    = comptr_inc;
  assign bus.freenum     = freenum;
  assign bus.rrfptr      = rrfptr;

  a_req_legal: assert property (@(posedge clk) disable iff (reset)
    bus.req_num != 2'd3);

  a_com_legal: assert property (@(posedge clk) disable iff (reset)
    RRF_CNT_LEN'(bus.com_num) <= (RRF_CNT_LEN'(RRF_NUM) - freenum));

  a_ptr_gap: assert property (@(posedge clk) disable iff (reset)
    (rrfptr - comptr) == used_from_free(freenum));

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Randomized and directed bench for rrf_alloc_ctrl against a queue-based occupancy model.
module tb_rrf_alloc_ctrl;
  import rrf_alloc_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  rrf_alloc_ctrl_if bus ();

  rrf_alloc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: tags in flight in allocation order, plus next-allocate and oldest-commit positions.
  int q[$];
  int aptr;
  int cptr;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_free();
    return 64 - q.size();
  endfunction

  // One cycle: drive, check same-cycle outputs, clock, update model, check registered state.
  task automatic step(input bit rst, input int req, input bit stall, input int com, input bit prm);
    bit ok;
    bit go;
    reset        = rst;
    bus.req_num  = 2'(req);
    bus.stall_dp = stall;
    bus.com_num  = 2'(com);
    bus.prmiss   = prm;
    #1;
    ok = (req <= m_free());
    go = ok && !stall && !prm;
    if (!rst) begin
      check("allocatable", int'(bus.allocatable), int'(ok));
      check("alloc_en1",   int'(bus.alloc_en1),   int'(go && req >= 1));
      check("alloc_en2",   int'(bus.alloc_en2),   int'(go && req == 2));
      check("alloc_tag1",  int'(bus.alloc_tag1),  aptr);
      check("alloc_tag2",  int'(bus.alloc_tag2),  (aptr + 1) % 64);
      check("com_tag1",    int'(bus.com_tag1),    cptr);
      check("com_tag2",    int'(bus.com_tag2),    (cptr + 1) % 64);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      aptr = 0;
      cptr = 0;
    end else begin
      for (int i = 0; i < com; i++) begin
        if (q.size() > 0) void'(q.pop_front());
        cptr = (cptr + 1) % 64;
      end
      if (prm) begin
        q.delete();
        aptr = cptr;
      end else if (go) begin
        for (int i = 0; i < req; i++) begin
          q.push_back(aptr);
          aptr = (aptr + 1) % 64;
        end
      end
    end
    #1;
    check("freenum",  int'(bus.freenum),  m_free());
    check("rrfptr",   int'(bus.rrfptr),   aptr);
    check("com_ptr",  int'(bus.com_tag1), cptr);
  endtask

  initial begin
    int req;
    int com;
    int cmax;
    bit stall;
    bit prm;
    bit rst;
    n_total = 0;
    n_bad   = 0;
    aptr    = 0;
    cptr    = 0;
    reset        = 1'b1;
    bus.req_num  = 2'd0;
    bus.stall_dp = 1'b0;
    bus.com_num  = 2'd0;
    bus.prmiss   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_freenum",  int'(bus.freenum),     64);
    check("rst_rrfptr",   int'(bus.rrfptr),      0);
    check("rst_tag1",     int'(bus.alloc_tag1),  0);
    check("rst_tag2",     int'(bus.alloc_tag2),  1);
    check("rst_ctag1",    int'(bus.com_tag1),    0);
    check("rst_ctag2",    int'(bus.com_tag2),    1);
    check("rst_alloc_ok", int'(bus.allocatable), 1);
    check("rst_en1",      int'(bus.alloc_en1),   0);

    repeat (3) step(0, 2, 0, 0, 0);
    check("plan_free58", int'(bus.freenum), 58);
    check("plan_ptr6",   int'(bus.rrfptr),  6);

    // Fill to 63 used, then probe the full boundary.
    repeat (28) step(0, 2, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("plan_free1", int'(bus.freenum), 1);
    step(0, 2, 0, 0, 0);
    check("plan_tag63", int'(bus.alloc_tag1), 63);
    step(0, 1, 0, 0, 0);
    check("plan_full", int'(bus.freenum), 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0);
    check("plan_free2", int'(bus.freenum),    2);
    check("plan_wrap",  int'(bus.alloc_tag1), 0);

    // Mispredict with rrfptr=10, comptr=4.
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 2, 0, 0, 0);
    repeat (2) step(0, 0, 0, 2, 0);
    check("plan_pre_ptr10", int'(bus.rrfptr),   10);
    check("plan_pre_com4",  int'(bus.com_tag1), 4);
    step(0, 2, 0, 1, 1);
    check("plan_miss_ptr", int'(bus.rrfptr),   5);
    check("plan_miss_com", int'(bus.com_tag1), 5);
    check("plan_miss_free", int'(bus.freenum), 64);

    // Stall blocks allocation; commit still advances.
    step(0, 2, 1, 0, 0);
    check("plan_stall_ptr", int'(bus.rrfptr), 5);
    step(0, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("plan_stall_com", int'(bus.com_tag1), 6);

    // Reset mid-operation at freenum=20 with mispredict asserted.
    while (m_free() > 20) step(0, 1, 0, 0, 0);
    check("plan_free20", int'(bus.freenum), 20);
    step(1, 2, 0, 0, 1);
    check("plan_rst_ptr",  int'(bus.rrfptr),   0);
    check("plan_rst_free", int'(bus.freenum),  64);
    check("plan_rst_com",  int'(bus.com_tag1), 0);

    // Random legal traffic, biased toward allocation so the full boundary is reached.
    for (int n = 0; n < 3000; n++) begin
      req   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 2)) : 0;
      cmax  = (q.size() < 2) ? q.size() : 2;
      com   = ($urandom_range(0, 9) < 4) ? int'($urandom_range(0, cmax)) : 0;
      stall = ($urandom_range(0, 7) == 0);
      prm   = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      step(rst, req, stall, com, prm);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
